// File: rtl/fifo_pkg.sv
`default_nettype none
//==============================================================================
// Package     : fifo_pkg
// Description : Shared definitions for the fifo_sync family: burst-reader FSM
//               state encoding and a constant-evaluable ceil(log2) helper.
// Revision    : 1.0 - initial release
//==============================================================================
package fifo_pkg;

    // Burst-reader FSM state encoding
    localparam logic [0:0] c_ST_IDLE  = 1'b0;
    localparam logic [0:0] c_ST_BURST = 1'b1;

    // ceil(log2(value)); returns 0 for value <= 1
    function automatic int clog2(input int value);
        int result;
        result = 0;
        while ((1 << result) < value) result = result + 1;
        return result;
    endfunction

endpackage
`default_nettype wire

// File: rtl/stream_skid_buf.sv
`default_nettype none
//==============================================================================
// Module      : stream_skid_buf
// Description : Two-entry valid/ready buffer with fully registered outputs.
//               s_ready is a flop, so the producer sees the buffer state of the
//               previous edge; the second entry absorbs the word that is already
//               in flight when the buffer fills.
// Ports       : clk, rst      - clock, asynchronous active-high reset
//               s_valid/s_ready/s_data - upstream handshake and payload
//               m_valid/m_ready/m_data - downstream handshake and payload
// Revision    : 1.0 - initial release
//==============================================================================
module stream_skid_buf #(
    parameter int W = 9
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         s_valid,
    output logic         s_ready,
    input  logic [W-1:0] s_data,
    output logic         m_valid,
    input  logic         m_ready,
    output logic [W-1:0] m_data
);

    logic [1:0]   r_cnt;
    logic [W-1:0] r_head;
    logic [W-1:0] r_tail;
    logic         r_s_ready;
    logic         r_m_valid;
    logic         w_push;
    logic         w_pop;
    logic [1:0]   w_cnt_nxt;

    assign w_push  = s_valid && r_s_ready;
    assign w_pop   = r_m_valid && m_ready;
    assign s_ready = r_s_ready;
    assign m_valid = r_m_valid;
    assign m_data  = r_head;

    always_comb begin
        w_cnt_nxt = r_cnt;
        if (w_push && !w_pop) begin
            w_cnt_nxt = r_cnt + 2'd1;
        end else if (!w_push && w_pop) begin
            w_cnt_nxt = r_cnt - 2'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt     <= 2'd0;
            r_head    <= '0;
            r_tail    <= '0;
            r_s_ready <= 1'b1;
            r_m_valid <= 1'b0;
        end else begin
            r_cnt     <= w_cnt_nxt;
            r_m_valid <= (w_cnt_nxt != 2'd0);
            r_s_ready <= (w_cnt_nxt != 2'd2);
            if (w_pop) begin
                // A full buffer never accepts, so push+pop only occurs at one entry
                if (r_cnt == 2'd2) begin
                    r_head <= r_tail;
                end else if (w_push) begin
                    r_head <= s_data;
                end
            end else if (w_push) begin
                if (r_cnt == 2'd0) begin
                    r_head <= s_data;
                end else begin
                    r_tail <= s_data;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/fifo_burst_reader.sv
`default_nettype none
//==============================================================================
// Module      : fifo_burst_reader
// Description : Drains a FWFT fifo_sync read port into bounded bursts on a
//               valid/ready stream with a last flag. Full bursts of BURST_LEN
//               start once enough words are buffered; a partial burst is flushed
//               after data has waited TIMEOUT cycles (TIMEOUT=0 disables it).
// Ports       : clk, rst                 - clock, asynchronous active-high reset
//               fifo_dout/fifo_empty     - FWFT head word and empty flag
//               fifo_rd_space            - registered fifo occupancy (AW+1 bits)
//               fifo_rd_en               - pop request, only while non-empty
//               m_valid/m_data/m_last    - output stream, m_last ends a burst
//               m_ready                  - downstream accept
//               busy                     - FSM is not idle
// Revision    : 1.0 - initial release
//==============================================================================
module fifo_burst_reader
    import fifo_pkg::*;
#(
    parameter int DW        = 8,
    parameter int AW        = 8,
    parameter int BURST_LEN = 16,
    parameter int TIMEOUT   = 64
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [DW-1:0] fifo_dout,
    input  logic          fifo_empty,
    input  logic [AW:0]   fifo_rd_space,
    output logic          fifo_rd_en,
    output logic          m_valid,
    output logic [DW-1:0] m_data,
    output logic          m_last,
    input  logic          m_ready,
    output logic          busy
);

    // A zero-width counter is illegal, so keep at least one bit when TIMEOUT=0
    localparam int c_WAIT_BITS = clog2(TIMEOUT + 1);
    localparam int c_WAIT_W    = (c_WAIT_BITS < 1) ? 1 : c_WAIT_BITS;

    localparam logic [AW:0]         c_BURST_LEN  = (AW+1)'(BURST_LEN);
    localparam logic [AW:0]         c_ONE        = (AW+1)'(1);
    localparam logic [c_WAIT_W-1:0] c_WAIT_MAX   = c_WAIT_W'(TIMEOUT);
    localparam logic [c_WAIT_W-1:0] c_WAIT_LIM   = c_WAIT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
    localparam logic [c_WAIT_W-1:0] c_WAIT_ONE   = c_WAIT_W'(1);
    localparam logic                c_TIMEOUT_EN = (TIMEOUT != 0);

    logic [0:0]          r_state;
    logic [AW:0]         r_len;
    logic [AW:0]         r_beat_cnt;
    logic [c_WAIT_W-1:0] r_wait_cnt;

    logic          w_skid_ready;
    logic          w_last_beat;
    logic [DW:0]   w_skid_dout;

    assign w_last_beat = (r_beat_cnt == (r_len - c_ONE));

    // Pop decision ignores m_ready entirely; the skid buffer decouples it
    assign fifo_rd_en = (r_state == c_ST_BURST) && !fifo_empty && w_skid_ready;
    assign busy       = (r_state == c_ST_BURST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= c_ST_IDLE;
            r_len      <= '0;
            r_beat_cnt <= '0;
            r_wait_cnt <= '0;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    if (fifo_empty) begin
                        r_wait_cnt <= '0;
                    end else if (r_wait_cnt != c_WAIT_MAX) begin
                        r_wait_cnt <= r_wait_cnt + c_WAIT_ONE;
                    end
                    // Full-burst start takes priority over the timeout flush
                    if (fifo_rd_space >= c_BURST_LEN) begin
                        r_len      <= c_BURST_LEN;
                        r_state    <= c_ST_BURST;
                        r_wait_cnt <= '0;
                    end else if (c_TIMEOUT_EN && (r_wait_cnt >= c_WAIT_LIM) &&
                                 (fifo_rd_space != '0)) begin
                        r_len      <= fifo_rd_space;
                        r_state    <= c_ST_BURST;
                        r_wait_cnt <= '0;
                    end
                end
                c_ST_BURST: begin
                    // len never exceeds occupancy at latch time, so an empty
                    // fifo here is only a transient refill stall
                    if (fifo_rd_en) begin
                        if (w_last_beat) begin
                            r_beat_cnt <= '0;
                            r_state    <= c_ST_IDLE;
                        end else begin
                            r_beat_cnt <= r_beat_cnt + c_ONE;
                        end
                    end
                end
                default: r_state <= c_ST_IDLE;
            endcase
        end
    end

    stream_skid_buf #(
        .W (DW + 1)
    ) u_skid (
        .clk     (clk),
        .rst     (rst),
        .s_valid (fifo_rd_en),
        .s_ready (w_skid_ready),
        .s_data  ({fifo_dout, w_last_beat}),
        .m_valid (m_valid),
        .m_ready (m_ready),
        .m_data  (w_skid_dout)
    );

    assign m_data = w_skid_dout[DW:1];
    assign m_last = w_skid_dout[0];

`ifndef SYNTHESIS
    always @(posedge clk) begin
        if (!rst) begin
            assert (!(fifo_rd_en && fifo_empty))
                else $error("fifo_burst_reader: fifo_rd_en asserted while fifo_empty");
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_fifo_burst_reader.sv
`default_nettype none
//==============================================================================
// Module      : tb_fifo_burst_reader
// Description : Self-checking bench for fifo_burst_reader with a behavioural
//               FWFT fifo (16 deep) in front of two instances: dut0 with
//               BURST_LEN=4, TIMEOUT=8 and dut1 with BURST_LEN=4, TIMEOUT=0.
// Revision    : 1.0 - initial release
//==============================================================================
module tb_fifo_burst_reader;

    localparam int DW = 8;
    localparam int AW = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- behavioural FWFT fifos (one per DUT) ----------------
    logic [1:0]    wr_en;
    logic [DW-1:0] wr_data;
    logic [DW-1:0] fmem [2][16];
    logic [3:0]    frp  [2];
    logic [3:0]    fwp  [2];
    logic [AW:0]   fcnt [2];
    logic [DW-1:0] f_dout  [2];
    logic          f_empty [2];

    logic          rd_en [2];
    logic          mv    [2];
    logic [DW-1:0] md    [2];
    logic          ml    [2];
    logic          mr    [2];
    logic          busy  [2];

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < 2; k++) begin
                frp[k]  <= '0;
                fwp[k]  <= '0;
                fcnt[k] <= '0;
            end
        end else begin
            for (int k = 0; k < 2; k++) begin
                if (wr_en[k]) begin
                    fmem[k][fwp[k]] <= wr_data;
                    fwp[k]          <= fwp[k] + 4'd1;
                end
                if (rd_en[k]) frp[k] <= frp[k] + 4'd1;
                fcnt[k] <= fcnt[k] + (AW+1)'(wr_en[k]) - (AW+1)'(rd_en[k]);
            end
        end
    end

    always_comb begin
        for (int k = 0; k < 2; k++) begin
            f_dout[k]  = fmem[k][frp[k]];
            f_empty[k] = (fcnt[k] == '0);
        end
    end

    fifo_burst_reader #(.DW(DW), .AW(AW), .BURST_LEN(4), .TIMEOUT(8)) dut0 (
        .clk(clk), .rst(rst),
        .fifo_dout(f_dout[0]), .fifo_empty(f_empty[0]), .fifo_rd_space(fcnt[0]),
        .fifo_rd_en(rd_en[0]),
        .m_valid(mv[0]), .m_data(md[0]), .m_last(ml[0]), .m_ready(mr[0]),
        .busy(busy[0])
    );

    fifo_burst_reader #(.DW(DW), .AW(AW), .BURST_LEN(4), .TIMEOUT(0)) dut1 (
        .clk(clk), .rst(rst),
        .fifo_dout(f_dout[1]), .fifo_empty(f_empty[1]), .fifo_rd_space(fcnt[1]),
        .fifo_rd_en(rd_en[1]),
        .m_valid(mv[1]), .m_data(md[1]), .m_last(ml[1]), .m_ready(mr[1]),
        .busy(busy[1])
    );

    // ---------------- output monitor ----------------
    logic [DW-1:0] cap_d0 [$];
    logic          cap_l0 [$];
    int            cap_c0 [$];
    logic [DW-1:0] cap_d1 [$];
    logic          cap_l1 [$];

    int            stall_err  = 0;
    int            stall_seen = 0;
    int            occ_err    = 0;
    int            rdempty_err = 0;
    int            busy_rise  = -1;
    int            occ_q      = 0;
    int            w_occ;
    logic          prev_push  = 1'b0;
    logic          prev_pop   = 1'b0;
    logic          prev_stall = 1'b0;
    logic          prev_full_rd = 1'b0;
    logic          prev_busy  = 1'b0;
    logic [DW-1:0] prev_d     = '0;
    logic          prev_l     = 1'b0;

    // Modelled skid occupancy of dut0 as seen after the most recent edge
    always_comb w_occ = occ_q + int'(prev_push) - int'(prev_pop);

    always @(negedge clk) begin
        if (rst) begin
            occ_q        <= 0;
            prev_push    <= 1'b0;
            prev_pop     <= 1'b0;
            prev_stall   <= 1'b0;
            prev_full_rd <= 1'b0;
            prev_busy    <= 1'b0;
        end else begin
            occ_q     <= w_occ;
            prev_push <= rd_en[0];
            prev_pop  <= mv[0] && mr[0];
            if (w_occ > 2 || w_occ < 0) occ_err <= occ_err + 1;
            // Popping into a full buffer is tolerated for one cycle at most
            prev_full_rd <= (w_occ == 2) && rd_en[0];
            if (prev_full_rd && (w_occ == 2) && rd_en[0]) occ_err <= occ_err + 1;
            if (prev_stall && (!mv[0] || md[0] !== prev_d || ml[0] !== prev_l))
                stall_err <= stall_err + 1;
            if (mv[0] && !mr[0]) stall_seen <= stall_seen + 1;
            prev_stall <= mv[0] && !mr[0];
            prev_d     <= md[0];
            prev_l     <= ml[0];
            if (mv[0] && mr[0]) begin
                cap_d0.push_back(md[0]);
                cap_l0.push_back(ml[0]);
                cap_c0.push_back(cyc);
            end
            if (mv[1] && mr[1]) begin
                cap_d1.push_back(md[1]);
                cap_l1.push_back(ml[1]);
            end
            if (busy[0] && !prev_busy) busy_rise <= cyc;
            prev_busy <= busy[0];
            if ((rd_en[0] && f_empty[0]) || (rd_en[1] && f_empty[1]))
                rdempty_err <= rdempty_err + 1;
        end
    end

    // ---------------- checking helpers ----------------
    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        logic [DW-1:0] wdata;
        logic [DW-1:0] exp_data;
        logic          exp_last;
    } vec_t;
    vec_t tbl [17];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_word(input int k, input logic [DW-1:0] d);
        wr_data   = d;
        wr_en[k]  = 1'b1;
        tick();
        wr_en[k]  = 1'b0;
    endtask

    task automatic wait_cap(input int k, input int n, input int budget);
        for (int i = 0; i < budget; i++) begin
            if (((k == 0) ? cap_d0.size() : cap_d1.size()) >= n) break;
            tick();
        end
    endtask

    task automatic cmp_range(input int first, input int count, input int base);
        for (int i = 0; i < count; i++) begin
            if (base + i < cap_d0.size()) begin
                check($sformatf("vec%0d data", first + i), 32'(cap_d0[base + i]),
                      32'(tbl[first + i].exp_data));
                check($sformatf("vec%0d last", first + i), 32'(cap_l0[base + i]),
                      32'(tbl[first + i].exp_last));
            end else begin
                check($sformatf("vec%0d present", first + i), 32'd0, 32'd1);
            end
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    initial begin
        int base;
        int t_ne;
        int gaps;
        logic stalled;

        for (int i = 0; i < 8; i++)
            tbl[i] = '{8'(8'h10 + i), 8'(8'h10 + i), (i == 3 || i == 7)};
        for (int i = 0; i < 3; i++)
            tbl[8 + i] = '{8'(8'hA0 + i), 8'(8'hA0 + i), (i == 2)};
        for (int i = 0; i < 6; i++)
            tbl[11 + i] = '{8'(8'hB0 + i), 8'(8'hB0 + i), (i == 1 || i == 5)};

        rst = 1'b1; wr_en = '0; wr_data = '0; mr[0] = 1'b1; mr[1] = 1'b1;
        repeat (3) tick();

        // Reset state
        check("rst m_valid",    32'(mv[0]),    32'd0);
        check("rst m_data",     32'(md[0]),    32'd0);
        check("rst m_last",     32'(ml[0]),    32'd0);
        check("rst busy",       32'(busy[0]),  32'd0);
        check("rst fifo_rd_en", 32'(rd_en[0]), 32'd0);
        check("rst busy dut1",  32'(busy[1]),  32'd0);
        rst = 1'b0;
        repeat (2) tick();

        // 1. Eight words -> two full bursts, gap-free inside each burst
        base = cap_d0.size();
        for (int i = 0; i < 8; i++) write_word(0, tbl[i].wdata);
        wait_cap(0, base + 8, 100);
        check("t1 word count", 32'(cap_d0.size() - base), 32'd8);
        cmp_range(0, 8, base);
        gaps = 0;
        for (int i = 0; i < 7; i++)
            if (!tbl[i].exp_last && (base + i + 1 < cap_c0.size()) &&
                (cap_c0[base + i + 1] - cap_c0[base + i] != 1)) gaps++;
        check("t1 intra-burst gaps", 32'(gaps), 32'd0);
        repeat (5) tick();

        // 2. Three words -> timeout flush; FSM leaves IDLE 8 cycles after non-empty
        base = cap_d0.size();
        write_word(0, tbl[8].wdata);
        t_ne = cyc;
        write_word(0, tbl[9].wdata);
        write_word(0, tbl[10].wdata);
        wait_cap(0, base + 3, 40);
        check("t2 word count", 32'(cap_d0.size() - base), 32'd3);
        cmp_range(8, 3, base);
        check("t2 burst start delay", 32'(busy_rise - t_ne), 32'd8);
        if (cap_c0.size() > base)
            check("t2 first word delay", 32'(cap_c0[base] - t_ne), 32'd9);
        else
            check("t2 first word present", 32'd0, 32'd1);
        repeat (5) tick();

        // 3. Back-pressure 1,0,0,1,... -> order kept, outputs held, no overrun
        base = cap_d0.size();
        for (int i = 0; i < 4; i++) write_word(0, 8'(8'h30 + i));
        for (int i = 0; i < 40; i++) begin
            mr[0] = (i % 4 == 0) || (i % 4 == 3);
            tick();
        end
        mr[0] = 1'b1;
        wait_cap(0, base + 4, 20);
        check("t3 word count", 32'(cap_d0.size() - base), 32'd4);
        for (int i = 0; i < 4; i++) begin
            if (base + i < cap_d0.size()) begin
                check($sformatf("t3 data %0d", i), 32'(cap_d0[base + i]), 32'(8'h30 + i));
                check($sformatf("t3 last %0d", i), 32'(cap_l0[base + i]), 32'(i == 3));
            end else begin
                check($sformatf("t3 present %0d", i), 32'd0, 32'd1);
            end
        end
        check("t3 stall exercised", 32'(stall_seen > 0), 32'd1);
        check("t3 stall stability errors", 32'(stall_err), 32'd0);
        check("t3 skid overrun errors", 32'(occ_err), 32'd0);
        repeat (5) tick();

        // 4. Partial flush latches len=2 while writes continue
        base = cap_d0.size();
        write_word(0, tbl[11].wdata);
        t_ne = cyc;
        write_word(0, tbl[12].wdata);
        while (cyc < t_ne + 7) tick();
        for (int i = 13; i < 17; i++) write_word(0, tbl[i].wdata);
        wait_cap(0, base + 6, 60);
        check("t4 word count", 32'(cap_d0.size() - base), 32'd6);
        cmp_range(11, 6, base);
        repeat (5) tick();

        // 5. Reset while the third beat of a burst is pending
        base = cap_d0.size();
        mr[0] = 1'b0;
        for (int i = 0; i < 4; i++) write_word(0, 8'(8'hC0 + i));
        stalled = 1'b0;
        for (int i = 0; i < 30; i++) begin
            if (busy[0] && mv[0] && !rd_en[0]) begin
                stalled = 1'b1;
                break;
            end
            tick();
        end
        check("t5 stalled mid-burst", 32'(stalled), 32'd1);
        #2 rst = 1'b1;
        #1;
        check("t5 rst m_valid",    32'(mv[0]),    32'd0);
        check("t5 rst m_data",     32'(md[0]),    32'd0);
        check("t5 rst m_last",     32'(ml[0]),    32'd0);
        check("t5 rst busy",       32'(busy[0]),  32'd0);
        check("t5 rst fifo_rd_en", 32'(rd_en[0]), 32'd0);
        tick();
        rst = 1'b0;
        mr[0] = 1'b1;
        repeat (3) tick();
        check("t5 busy after release",    32'(busy[0]), 32'd0);
        check("t5 m_valid after release", 32'(mv[0]),   32'd0);
        repeat (20) tick();
        check("t5 no words after abort", 32'(cap_d0.size() - base), 32'd0);

        // 6. TIMEOUT=0: three words stay put, fourth triggers a full burst
        base = cap_d1.size();
        for (int i = 0; i < 3; i++) write_word(1, 8'(8'hD0 + i));
        repeat (30) tick();
        check("t6 no partial flush", 32'(cap_d1.size() - base), 32'd0);
        check("t6 idle before 4th",  32'(busy[1]), 32'd0);
        write_word(1, 8'hD3);
        wait_cap(1, base + 4, 30);
        check("t6 word count", 32'(cap_d1.size() - base), 32'd4);
        for (int i = 0; i < 4; i++) begin
            if (base + i < cap_d1.size()) begin
                check($sformatf("t6 data %0d", i), 32'(cap_d1[base + i]), 32'(8'hD0 + i));
                check($sformatf("t6 last %0d", i), 32'(cap_l1[base + i]), 32'(i == 3));
            end else begin
                check($sformatf("t6 present %0d", i), 32'd0, 32'd1);
            end
        end

        repeat (3) tick();
        check("rd_en while empty events", 32'(rdempty_err), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
